// File: rtl/fp_pkg.sv
// Shared widths, FSM state encoding and the single-precision operand layout
// used by the floating-point add alignment stage.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   // hidden bit + fraction + guard + round + sticky
   localparam int EXT_W = MAN_W + 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      SHIFT   = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] frac;
   } fp32_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits one IEEE-754 operand into sign, effective exponent, extended
// mantissa {hidden, frac, guard, round, sticky} and an Inf/NaN flag.
// Denormals take an effective exponent of 1 so they align like the smallest
// normal value.
module fp_unpack import fp_pkg::*; #(
   parameter int EXP_W = fp_pkg::EXP_W,
   parameter int MAN_W = fp_pkg::MAN_W,
   parameter int EXT_W = fp_pkg::EXT_W
) (
   input  logic [EXP_W+MAN_W:0] value,
   output logic                 sign,
   output logic [EXP_W-1:0]     exp_eff,
   output logic [EXT_W-1:0]     man,
   output logic                 is_special
);

   logic [EXP_W-1:0] exp_raw;
   logic [MAN_W-1:0] frac;
   logic             hidden;

   assign sign       = value[EXP_W+MAN_W];
   assign exp_raw    = value[EXP_W+MAN_W-1:MAN_W];
   assign frac       = value[MAN_W-1:0];
   assign hidden     = |exp_raw;
   assign exp_eff    = hidden ? exp_raw : EXP_W'(1);
   assign man        = {hidden, frac, 3'b000};
   assign is_special = &exp_raw;

endmodule

// File: rtl/fp_add_align.sv
// Alignment stage of a floating-point adder: orders two operands by
// magnitude and shifts the smaller mantissa right one bit per cycle until
// both share the larger exponent, folding lost bits into a sticky bit.
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and all outputs hold until out_ready is seen; neither ready input reaches
// any output combinationally.
module fp_add_align import fp_pkg::*; #(
   parameter int EXP_W = fp_pkg::EXP_W,
   parameter int MAN_W = fp_pkg::MAN_W,
   parameter int EXT_W = fp_pkg::EXT_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXT_W-1:0]     man_big,
   output logic [EXT_W-1:0]     man_small,
   output logic [EXP_W-1:0]     exp_out,
   output logic                 sign_out,
   output logic                 eff_sub,
   output logic                 special
);

   // Beyond this distance every bit of the small mantissa lands in sticky.
   localparam logic [EXP_W:0] D_MAX = (EXP_W+1)'(EXT_W - 1);
   localparam logic [EXP_W:0] ONE   = (EXP_W+1)'(1);

   state_t state, state_next;

   logic [EXP_W+MAN_W:0] a_r, b_r;
   logic                 sub_r;
   logic [EXP_W:0]       cnt;

   logic                 sa, sb, spa, spb;
   logic [EXP_W-1:0]     ea, eb;
   logic [EXT_W-1:0]     ma, mb;

   logic                 a_big;
   logic [EXP_W-1:0]     exp_big;
   logic [EXT_W-1:0]     mbig_c, msmall_c;
   logic [EXP_W:0]       d;
   logic                 far;
   logic                 any_special;

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .EXT_W(EXT_W)) u_unpack_a (
      .value      (a_r),
      .sign       (sa),
      .exp_eff    (ea),
      .man        (ma),
      .is_special (spa)
   );

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .EXT_W(EXT_W)) u_unpack_b (
      .value      (b_r),
      .sign       (sb),
      .exp_eff    (eb),
      .man        (mb),
      .is_special (spb)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Magnitude ordering and exponent distance; a wins ties.
   always_comb begin
      a_big       = (ea > eb) || ((ea == eb) && (ma >= mb));
      exp_big     = a_big ? ea : eb;
      mbig_c      = a_big ? ma : mb;
      msmall_c    = a_big ? mb : ma;
      d           = a_big ? ({1'b0, ea} - {1'b0, eb}) : ({1'b0, eb} - {1'b0, ea});
      far         = (d > D_MAX);
      any_special = spa | spb;
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = COMPARE;
         COMPARE: begin
            if (any_special || (d == '0) || far) state_next = DONE;
            else                                 state_next = SHIFT;
         end
         SHIFT:   if (cnt == ONE) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Operand capture, result registers and the one-bit-per-cycle shifter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_r       <= '0;
         b_r       <= '0;
         sub_r     <= 1'b0;
         cnt       <= '0;
         man_big   <= '0;
         man_small <= '0;
         exp_out   <= '0;
         sign_out  <= 1'b0;
         eff_sub   <= 1'b0;
         special   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= b;
                  sub_r <= sub;
               end
            end
            COMPARE: begin
               exp_out  <= exp_big;
               sign_out <= a_big ? sa : (sb ^ sub_r);
               eff_sub  <= sa ^ sb ^ sub_r;
               special  <= any_special;
               if (any_special) begin
                  man_big   <= '0;
                  man_small <= '0;
               end else if (far) begin
                  man_big   <= mbig_c;
                  man_small <= {{(EXT_W-1){1'b0}}, |msmall_c};
               end else begin
                  man_big   <= mbig_c;
                  man_small <= msmall_c;
                  cnt       <= d;
               end
            end
            SHIFT: begin
               man_small <= {1'b0, man_small[EXT_W-1:2], man_small[1] | man_small[0]};
               cnt       <= cnt - ONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_align.sv
// Bench for fp_add_align: directed vector table, randomized vectors checked
// against an arithmetic reference model, back-pressure and mid-shift reset.
module tb_fp_add_align;
   import fp_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [26:0] man_big, man_small;
   logic [7:0]  exp_out;
   logic        sign_out, eff_sub, special;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [7:0]  exp;
      logic [26:0] mb;
      logic [26:0] ms;
      logic        sign;
      logic        eff;
      logic        spec;
      int          lat;
   } vec_t;

   fp_add_align dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .man_big   (man_big),
      .man_small (man_small),
      .exp_out   (exp_out),
      .sign_out  (sign_out),
      .eff_sub   (eff_sub),
      .special   (special)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: align with plain integer arithmetic.
   function automatic vec_t model(input logic [31:0] xa, input logic [31:0] xb, input logic xs);
      vec_t   v;
      longint ea, eb, ma, mb, be, se, bm, sm, d, lost;
      bit     a_big;
      ea = longint'(xa[30:23]);
      eb = longint'(xb[30:23]);
      ma = ((ea != 0 ? longint'(1) << 23 : 0) + longint'(xa[22:0])) * 8;
      mb = ((eb != 0 ? longint'(1) << 23 : 0) + longint'(xb[22:0])) * 8;
      if (ea == 0) ea = 1;
      if (eb == 0) eb = 1;
      a_big = (ea > eb) || (ea == eb && ma >= mb);
      be = a_big ? ea : eb;
      se = a_big ? eb : ea;
      bm = a_big ? ma : mb;
      sm = a_big ? mb : ma;
      d  = be - se;
      v.a    = xa;
      v.b    = xb;
      v.sub  = xs;
      v.exp  = be[7:0];
      v.sign = a_big ? xa[31] : (xb[31] ^ xs);
      v.eff  = xa[31] ^ xb[31] ^ xs;
      v.spec = (xa[30:23] == 8'hFF) || (xb[30:23] == 8'hFF);
      if (v.spec) begin
         v.mb = '0; v.ms = '0; v.lat = 2;
      end else if (d == 0) begin
         v.mb = bm[26:0]; v.ms = sm[26:0]; v.lat = 2;
      end else if (d > 26) begin
         v.mb = bm[26:0]; v.ms = (sm != 0) ? 27'd1 : 27'd0; v.lat = 2;
      end else begin
         lost = sm % (longint'(1) << d);
         sm   = (sm >> d) | ((lost != 0) ? 1 : 0);
         v.mb = bm[26:0]; v.ms = sm[26:0]; v.lat = 2 + int'(d);
      end
      return v;
   endfunction

   function automatic vec_t mk(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                               input logic [7:0] e, input logic [26:0] mbv, input logic [26:0] msv,
                               input logic sg, input logic ef, input logic sp, input int lt);
      vec_t v;
      v.a = xa; v.b = xb; v.sub = xs; v.exp = e; v.mb = mbv; v.ms = msv;
      v.sign = sg; v.eff = ef; v.spec = sp; v.lat = lt;
      return v;
   endfunction

   // Drive one operation from IDLE (called #1 after a posedge), wait for
   // out_valid within a cycle budget and compare all outputs.
   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      check({tag, "_in_ready"}, in_ready, 1);
      a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"},   cyc, v.lat);
      check({tag, "_exp_out"},   exp_out, v.exp);
      check({tag, "_man_big"},   man_big, v.mb);
      check({tag, "_man_small"}, man_small, v.ms);
      check({tag, "_sign_out"},  sign_out, v.sign);
      check({tag, "_eff_sub"},   eff_sub, v.eff);
      check({tag, "_special"},   special, v.spec);
      @(posedge clk); #1;
   endtask

   vec_t dir_q[$];
   vec_t v036;

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0;

      // Directed table.
      v036 = mk(32'h40400000, 32'h3F800000, 1'b0, 8'h80, 27'h6000000, 27'h2000000, 0, 0, 0, 3);
      dir_q.push_back(v036);
      dir_q.push_back(mk(32'h3F800000, 32'h3F800000, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 0, 1, 0, 2));
      dir_q.push_back(mk(32'h4E800000, 32'h3F800000, 1'b0, 8'h9D, 27'h4000000, 27'h0000001, 0, 0, 0, 2));
      dir_q.push_back(mk(32'h7F800000, 32'h3F800000, 1'b0, 8'hFF, 27'h0,       27'h0,       0, 0, 1, 2));
      dir_q.push_back(mk(32'h3F800000, 32'hC0000000, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1, 1, 0, 3));
      dir_q.push_back(mk(32'h00000001, 32'h00800000, 1'b1, 8'h01, 27'h4000000, 27'h0000008, 1, 1, 0, 2));
      dir_q.push_back(mk(32'h42000000, 32'h3F800001, 1'b0, 8'h84, 27'h4000000, 27'h0200001, 0, 0, 0, 7));
      // d = 26: longest shift, hidden bit lands in bit 0
      dir_q.push_back(mk(32'h4C800000, 32'h3F800000, 1'b0, 8'h99, 27'h4000000, 27'h0000001, 0, 0, 0, 28));

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_man_big",   man_big, 0);
      check("rst_man_small", man_small, 0);
      check("rst_exp_out",   exp_out, 0);
      check("rst_flags",     {sign_out, eff_sub, special}, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);

      foreach (dir_q[i]) run_vec(dir_q[i], $sformatf("dir%0d", i));

      // Randomized vectors against the model.
      for (int i = 0; i < 150; i++) begin
         logic [7:0]  ea, eb;
         logic [31:0] ra, rb;
         int          e2;
         ea = 8'($urandom_range(0, 254));
         e2 = int'(ea) + $urandom_range(0, 60) - 30;
         if (e2 < 0) e2 = 0;
         if (e2 > 254) e2 = 254;
         eb = 8'(e2);
         if ($urandom_range(0, 15) == 0) ea = 8'hFF;
         if ($urandom_range(0, 15) == 0) eb = 8'hFF;
         if ($urandom_range(0, 7) == 0) ea = 8'h00;
         ra = {1'($urandom), ea, 23'($urandom)};
         rb = {1'($urandom), eb, 23'($urandom)};
         if ($urandom_range(0, 9) == 0) rb = ra;
         run_vec(model(ra, rb, 1'($urandom)), $sformatf("rnd%0d", i));
      end

      // Back-pressure: result must hold while out_ready is low.
      begin
         int bad, cyc;
         bad = 0;
         out_ready = 1'b0;
         a = v036.a; b = v036.b; sub = v036.sub; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         cyc = 1;
         while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("bp_latency", cyc, 3);
         for (int k = 0; k < 10; k++) begin
            if (!out_valid || in_ready || man_big != v036.mb || man_small != v036.ms ||
                exp_out != v036.exp || sign_out != v036.sign || eff_sub != v036.eff ||
                special != v036.spec) bad++;
            @(posedge clk); #1;
         end
         check("bp_hold_bad_cycles", bad, 0);
         out_ready = 1'b1;
         @(posedge clk); #1;
         check("bp_release_in_ready", in_ready, 1);
         check("bp_release_out_valid", out_valid, 0);
      end

      // Reset during SHIFT of a d=20 operation.
      begin
         int pulses;
         pulses = 0;
         a = 32'h49800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         for (int k = 0; k < 6; k++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
         end
         reset_n = 1'b0;
         @(posedge clk); #1;
         check("mid_rst_in_ready",  in_ready, 1);
         check("mid_rst_outputs",   {out_valid, sign_out, eff_sub, special}, 0);
         check("mid_rst_man_big",   man_big, 0);
         check("mid_rst_man_small", man_small, 0);
         check("mid_rst_exp_out",   exp_out, 0);
         reset_n = 1'b1;
         for (int k = 0; k < 30; k++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
         end
         check("mid_rst_no_out_valid", pulses, 0);
         check("mid_rst_idle_after", in_ready, 1);
      end

      // One more operation after the abandoned one still works.
      run_vec(model(32'h41200000, 32'h3E000000, 1'b1), "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_add_align.md
FP_ADD_ALIGN -- requirements
Module: fp_add_align

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning the exponent width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning the stored fraction width.
REQ-003 The block SHALL have parameter EXT_W, default MAN_W+4 (27), meaning the extended mantissa width: hidden bit, fraction, guard, round and sticky.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_valid / in_ready, input / output, 1 bit each: the upstream handshake.
REQ-007 The block SHALL have ports a and b, inputs, 1+EXP_W+MAN_W bits each: the IEEE-754 operands.
REQ-008 The block SHALL have port sub, input, 1 bit: 1 selects a-b, 0 selects a+b.
REQ-009 The block SHALL have port out_valid / out_ready, output / input, 1 bit each: the downstream handshake towards the ripple-carry adder.
REQ-010 The block SHALL have port man_big, output, EXT_W bits: the larger-magnitude mantissa, unshifted.
REQ-011 The block SHALL have port man_small, output, EXT_W bits: the smaller mantissa, aligned, with sticky in bit 0.
REQ-012 The block SHALL have port exp_out, output, EXP_W bits: the common exponent, equal to the larger operand's exponent.
REQ-013 The block SHALL have port sign_out, output, 1 bit: the sign of the larger-magnitude operand after sub is applied.
REQ-014 The block SHALL have port eff_sub, output, 1 bit: effective subtraction, defined as sign(a) xor sign(b) xor sub.
REQ-015 The block SHALL have port special, output, 1 bit: either operand has an all-ones exponent (Inf/NaN).

Function
REQ-016 The FSM SHALL have states IDLE, COMPARE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an operand pair is accepted on in_valid & in_ready, then the FSM moves to COMPARE.
REQ-018 Unpacking SHALL give hidden bit = (exp != 0); a denormal (exp 0) SHALL use an effective exponent of 1; the extended mantissa SHALL be {hidden, frac, 3'b000}.
REQ-019 COMPARE SHALL order the operands by exponent, then by mantissa; on equal magnitudes a is the big operand.
REQ-020 COMPARE SHALL compute d = exp_big - exp_small.
REQ-021 From COMPARE, if special then the FSM SHALL go to DONE with both mantissas 0.
REQ-022 From COMPARE, if d = 0 then the FSM SHALL go to DONE.
REQ-023 From COMPARE, if d > EXT_W-1 then the FSM SHALL go to DONE with man_small = {0..., |small_mantissa}.
REQ-024 From COMPARE, in every other case the FSM SHALL load counter = d and go to SHIFT.
REQ-025 In SHIFT, each cycle the block SHALL shift man_small right by 1 and OR the shifted-out bit into bit 0 (sticky), then decrement the counter; it SHALL go to DONE when the counter reaches 1 in the same cycle it performs the last shift.
REQ-026 Latency SHALL be as follows: if accepted at cycle N, out_valid asserts at N+2 when d = 0, d > 26 or special, and at N+2+d otherwise.
REQ-027 In DONE, out_valid SHALL be 1 and every output SHALL be held stable until out_ready; on out_valid & out_ready the FSM SHALL go to IDLE, and the next accept is possible on the following cycle.
REQ-028 Outputs SHALL be registered; there SHALL be no combinational path from in_valid or out_ready to outputs other than none (in_ready is decoded from state only).
REQ-029 The exponent difference SHALL be computed at EXP_W+1 bits, so it never wraps.

Reset
REQ-030 When reset_n = 0 at a clk edge, state SHALL become IDLE and out_valid, special, eff_sub, sign_out, man_big, man_small, exp_out and the counter SHALL all become 0.
REQ-031 Reset asserted mid-operation (COMPARE, SHIFT or DONE) SHALL abandon the operation with no output handshake.
REQ-032 in_ready SHALL be 1 on the first cycle after reset is released.

Structure
REQ-033 Package fp_pkg SHALL hold EXP_W, MAN_W, EXT_W, the state enum and a packed fp32 struct {sign, exp, frac}.
REQ-034 A combinational sub-module, fp_unpack, SHALL map an fp32 value to {sign, effective exp, EXT_W mantissa, is_special}, and SHALL be instantiated twice.
REQ-035 man_big and man_small SHALL feed rippleCarryAdder with N = EXT_W directly.

Verification
REQ-036 Scenario: a=0x40400000, b=0x3F800000, sub=0 -> exp_out=0x80, man_big=27'h6000000, man_small=27'h2000000, eff_sub=0, out_valid at N+3.
REQ-037 Scenario: a=b=0x3F800000, sub=1 -> eff_sub=1, sign_out=0, man_big = man_small = 27'h4000000, out_valid at N+2.
REQ-038 Scenario: a=0x4E800000, b=0x3F800000 (d=30) -> man_small=27'h0000001, exp_out=0x9D, out_valid at N+2.
REQ-039 Scenario: a=0x7F800000, b=0x3F800000 -> special=1, out_valid at N+2.
REQ-040 Scenario: out_ready held 0 for 10 cycles after the REQ-036 result -> outputs unchanged and in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
REQ-041 Scenario: reset_n driven 0 during SHIFT of a d=20 operation -> the next cycle is IDLE, all outputs 0, and out_valid never pulses.
